// File: rtl/arena_pkg.sv
// Shared constants, cell codes, FSM encoding and grid helpers for the arena grid.
package arena_pkg;

  localparam int unsigned ColsDef   = 80;
  localparam int unsigned RowsDef   = 60;
  localparam int unsigned BorderDef = 2;

  localparam int unsigned AddrW = 13;
  localparam int unsigned ColW  = 7;
  localparam int unsigned RowW  = 6;

  typedef logic [1:0] cell_t;

  localparam cell_t CellEmpty = 2'd0;
  localparam cell_t CellP1    = 2'd1;
  localparam cell_t CellWall  = 2'd2;
  localparam cell_t CellP2    = 2'd3;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StWrite,
    StCheck,
    StResult
  } state_e;

  // True when (col,row) lies inside a cols x rows grid.
  function automatic logic in_grid(logic [ColW-1:0] col, logic [RowW-1:0] row,
                                   int unsigned cols, int unsigned rows);
    return (32'(col) < cols) && (32'(row) < rows);
  endfunction

  // Row-major linear address of a cell.
  function automatic logic [AddrW-1:0] cell_addr(logic [ColW-1:0] col, logic [RowW-1:0] row,
                                                 int unsigned cols);
    return AddrW'(32'(row) * cols + 32'(col));
  endfunction

  // True for cells inside the wall band on any edge.
  function automatic logic is_border(logic [ColW-1:0] col, logic [RowW-1:0] row,
                                     int unsigned cols, int unsigned rows,
                                     int unsigned border);
    return (32'(row) < border) || (32'(row) >= rows - border) ||
           (32'(col) < border) || (32'(col) >= cols - border);
  endfunction

endpackage

// File: rtl/arena_grid_if.sv
// Move/clear/pixel signal bundle between the game logic (master) and the arena (slave).
interface arena_grid_if;
  import arena_pkg::*;

  logic                clear_req;
  logic                busy;
  logic                mv_valid;
  logic                mv_ready;
  logic                mv_player;
  logic [ColW-1:0]     mv_cur_col;
  logic [RowW-1:0]     mv_cur_row;
  logic [ColW-1:0]     mv_nxt_col;
  logic [RowW-1:0]     mv_nxt_row;
  logic                res_valid;
  logic                res_hit;
  logic                game_over;
  logic [ColW-1:0]     pix_col;
  logic [RowW-1:0]     pix_row;
  cell_t               pix_cell;

  modport master (
    output clear_req, mv_valid, mv_player, mv_cur_col, mv_cur_row, mv_nxt_col, mv_nxt_row,
           pix_col, pix_row,
    input  busy, mv_ready, res_valid, res_hit, game_over, pix_cell
  );

  modport slave (
    input  clear_req, mv_valid, mv_player, mv_cur_col, mv_cur_row, mv_nxt_col, mv_nxt_row,
           pix_col, pix_row,
    output busy, mv_ready, res_valid, res_hit, game_over, pix_cell
  );

endinterface

// File: rtl/arena_ram.sv
// Cell store: port A read/write for the sweep and moves, port B read-only for pixel lookup.
module arena_ram import arena_pkg::*; #(
  parameter int unsigned Depth = ColsDef * RowsDef
) (
  input  logic             clk_i,
  input  logic             a_we_i,
  input  logic [AddrW-1:0] a_addr_i,
  input  cell_t            a_wdata_i,
  output cell_t            a_rdata_o,
  input  logic [AddrW-1:0] b_addr_i,
  output cell_t            b_rdata_o
);

  cell_t mem_q [Depth];

  // Port A: synchronous write with registered read-before-write data.
  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
    a_rdata_o <= mem_q[a_addr_i];
  end

  // Port B: registered read.
  always_ff @(posedge clk_i) begin
    b_rdata_o <= mem_q[b_addr_i];
  end

endmodule

// File: rtl/arena_grid.sv
// Light-cycle arena: clears walls/floor, records trails, reports collisions, serves pixels.
module arena_grid import arena_pkg::*; #(
  parameter int unsigned COLS   = ColsDef,
  parameter int unsigned ROWS   = RowsDef,
  parameter int unsigned BORDER = BorderDef
) (
  input logic         CLOCK_50,
  input logic         reset,
  arena_grid_if.slave bus
);

  localparam int unsigned      Cells    = COLS * ROWS;
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Cells - 1);

  state_e state_q, state_d;

  logic             pend_q, pend_d;
  logic [ColW-1:0]  clr_col_q, clr_col_d;
  logic [RowW-1:0]  clr_row_q, clr_row_d;
  logic [AddrW-1:0] clr_addr_q, clr_addr_d;
  logic             game_over_q, game_over_d;
  logic             res_hit_q;
  logic             pix_oor_q, pix_busy_q;

  logic             mv_player_q;
  logic [ColW-1:0]  cur_col_q, nxt_col_q;
  logic [RowW-1:0]  cur_row_q, nxt_row_q;

  logic             a_we;
  logic [AddrW-1:0] a_addr, b_addr;
  cell_t            a_wdata, a_rdata, b_rdata;

  logic mv_ready, xfer, clr_last, cur_ok, nxt_ok, pix_ok, hit_now;

  assign xfer     = bus.mv_valid && mv_ready;
  assign clr_last = (clr_addr_q == LastAddr);
  assign cur_ok   = in_grid(cur_col_q, cur_row_q, COLS, ROWS);
  assign nxt_ok   = in_grid(nxt_col_q, nxt_row_q, COLS, ROWS);
  assign pix_ok   = in_grid(bus.pix_col, bus.pix_row, COLS, ROWS);
  // Off-grid targets collide without consulting memory.
  assign hit_now  = !nxt_ok || (a_rdata != CellEmpty);
  assign b_addr   = pix_ok ? cell_addr(bus.pix_col, bus.pix_row, COLS) : '0;

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= StClear;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a clear request always preempts a new move but never an in-flight one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: begin
        if (bus.clear_req) begin
          state_d = StClear;
        end else if (clr_last) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (bus.clear_req) begin
          state_d = StClear;
        end else if (xfer) begin
          state_d = StWrite;
        end
      end
      StWrite:  state_d = StCheck;
      StCheck:  state_d = StResult;
      StResult: state_d = (pend_q || bus.clear_req) ? StClear : StIdle;
      default:  state_d = StClear;
    endcase
  end

  // Outputs and RAM port A control decoded from the current state.
  always_comb begin
    bus.busy      = 1'b0;
    mv_ready      = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_hit   = res_hit_q;
    a_we          = 1'b0;
    a_addr        = '0;
    a_wdata       = CellEmpty;
    unique case (state_q)
      StClear: begin
        bus.busy = 1'b1;
        a_we     = 1'b1;
        a_addr   = clr_addr_q;
        a_wdata  = is_border(clr_col_q, clr_row_q, COLS, ROWS, BORDER) ? CellWall : CellEmpty;
      end
      StIdle: begin
        mv_ready = !pend_q && !bus.clear_req;
      end
      StWrite: begin
        // An off-grid current cell would alias another cell, so it is not stored.
        a_we    = cur_ok;
        a_addr  = cur_ok ? cell_addr(cur_col_q, cur_row_q, COLS) : '0;
        a_wdata = mv_player_q ? CellP2 : CellP1;
      end
      StCheck: begin
        a_addr = nxt_ok ? cell_addr(nxt_col_q, nxt_row_q, COLS) : '0;
      end
      StResult: begin
        bus.res_valid = 1'b1;
        bus.res_hit   = hit_now;
      end
      default: ;
    endcase
  end

  assign bus.mv_ready  = mv_ready;
  assign bus.game_over = game_over_q;
  assign bus.pix_cell  = pix_busy_q ? CellEmpty : (pix_oor_q ? CellWall : b_rdata);

  // Next values for the pending-clear flag, sweep counters and sticky collision flag.
  always_comb begin
    pend_d      = pend_q;
    clr_col_d   = clr_col_q;
    clr_row_d   = clr_row_q;
    clr_addr_d  = clr_addr_q;
    game_over_d = game_over_q;

    if ((state_q == StWrite || state_q == StCheck) && bus.clear_req) begin
      pend_d = 1'b1;
    end

    if (state_q == StResult && hit_now) begin
      game_over_d = 1'b1;
    end

    if (state_d == StClear && (state_q != StClear || bus.clear_req)) begin
      // Entering or restarting the sweep.
      pend_d      = 1'b0;
      game_over_d = 1'b0;
      clr_col_d   = '0;
      clr_row_d   = '0;
      clr_addr_d  = '0;
    end else if (state_q == StClear) begin
      if (clr_last) begin
        clr_col_d  = '0;
        clr_row_d  = '0;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + AddrW'(1);
        if (32'(clr_col_q) == COLS - 1) begin
          clr_col_d = '0;
          clr_row_d = clr_row_q + RowW'(1);
        end else begin
          clr_col_d = clr_col_q + ColW'(1);
        end
      end
    end
  end

  // Control and datapath registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pend_q      <= 1'b0;
      clr_col_q   <= '0;
      clr_row_q   <= '0;
      clr_addr_q  <= '0;
      game_over_q <= 1'b0;
      res_hit_q   <= 1'b0;
      pix_oor_q   <= 1'b0;
      pix_busy_q  <= 1'b1;
      mv_player_q <= 1'b0;
      cur_col_q   <= '0;
      cur_row_q   <= '0;
      nxt_col_q   <= '0;
      nxt_row_q   <= '0;
    end else begin
      pend_q      <= pend_d;
      clr_col_q   <= clr_col_d;
      clr_row_q   <= clr_row_d;
      clr_addr_q  <= clr_addr_d;
      game_over_q <= game_over_d;
      pix_oor_q   <= !pix_ok;
      pix_busy_q  <= (state_q == StClear);
      if (state_q == StResult) begin
        res_hit_q <= hit_now;
      end
      if (xfer) begin
        mv_player_q <= bus.mv_player;
        cur_col_q   <= bus.mv_cur_col;
        cur_row_q   <= bus.mv_cur_row;
        nxt_col_q   <= bus.mv_nxt_col;
        nxt_row_q   <= bus.mv_nxt_row;
      end
    end
  end

  arena_ram #(
    .Depth (Cells)
  ) u_ram (
    .clk_i     (CLOCK_50),
    .a_we_i    (a_we),
    .a_addr_i  (a_addr),
    .a_wdata_i (a_wdata),
    .a_rdata_o (a_rdata),
    .b_addr_i  (b_addr),
    .b_rdata_o (b_rdata)
  );

endmodule

// File: tb/tb_arena_grid.sv
// Directed bench for arena_grid: sweep length, wall layout, move latency/collisions, clears, resets.
module tb_arena_grid;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  arena_grid_if bus ();

  arena_grid #(
    .COLS   (80),
    .ROWS   (60),
    .BORDER (2)
  ) u_dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix_check(input string tag, input int c, input int r, input logic [1:0] exp);
    bus.pix_col = 7'(c);
    bus.pix_row = 6'(r);
    tick();
    check_eq(tag, 32'(bus.pix_cell), 32'(exp));
  endtask

  // Counts samples with busy high from the current sample on; a sweep is 4800.
  task automatic wait_sweep(input string tag);
    int cnt = 0;
    int rv  = 0;
    while (bus.busy && cnt < 6000) begin
      cnt++;
      if (bus.res_valid) rv++;
      tick();
    end
    check_eq({tag, " sweep len"}, cnt, 4800);
    check_eq({tag, " no res_valid"}, rv, 0);
  endtask

  // Sets up a move and waits (bounded) until it is ready to transfer on the next edge.
  task automatic offer_move(input string tag, input logic player, input int cc, input int cr,
                            input int nc, input int nr, output logic ok);
    int waited = 0;
    bus.mv_valid   = 1'b1;
    bus.mv_player  = player;
    bus.mv_cur_col = 7'(cc);
    bus.mv_cur_row = 6'(cr);
    bus.mv_nxt_col = 7'(nc);
    bus.mv_nxt_row = 6'(nr);
    while (!bus.mv_ready && waited < 20) begin
      tick();
      waited++;
    end
    ok = bus.mv_ready;
    check_eq({tag, " ready"}, 32'(ok), 1);
    if (!ok) bus.mv_valid = 1'b0;
  endtask

  // Transfer on edge N: res_valid is seen after edge N+2 (the cycle closed by edge N+3),
  // and mv_ready returns after edge N+3 so the next transfer can occur on edge N+4.
  task automatic do_move(input string tag, input logic player, input int cc, input int cr,
                         input int nc, input int nr, input logic exp_hit, input logic clr_mid);
    logic ok;
    offer_move(tag, player, cc, cr, nc, nr, ok);
    if (!ok) return;
    tick();  // edge N
    bus.mv_valid = 1'b0;
    if (clr_mid) bus.clear_req = 1'b1;
    check_eq({tag, " rv@N"}, 32'(bus.res_valid), 0);
    check_eq({tag, " rdy@N"}, 32'(bus.mv_ready), 0);
    tick();  // edge N+1
    bus.clear_req = 1'b0;
    check_eq({tag, " rv@N+1"}, 32'(bus.res_valid), 0);
    tick();  // edge N+2
    check_eq({tag, " rv@N+2"}, 32'(bus.res_valid), 1);
    check_eq({tag, " hit"}, 32'(bus.res_hit), 32'(exp_hit));
    tick();  // edge N+3
    check_eq({tag, " rv pulse"}, 32'(bus.res_valid), 0);
    check_eq({tag, " hit held"}, 32'(bus.res_hit), 32'(exp_hit));
    if (clr_mid) check_eq({tag, " busy"}, 32'(bus.busy), 1);
    else         check_eq({tag, " rdy again"}, 32'(bus.mv_ready), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.clear_req = 1'b0;
    bus.mv_valid  = 1'b0;
    bus.mv_player = 1'b0;
    bus.mv_cur_col = '0;
    bus.mv_cur_row = '0;
    bus.mv_nxt_col = '0;
    bus.mv_nxt_row = '0;
    bus.pix_col   = '0;
    bus.pix_row   = '0;

    repeat (3) tick();
    check_eq("rst busy", 32'(bus.busy), 1);
    check_eq("rst mv_ready", 32'(bus.mv_ready), 0);
    check_eq("rst res_valid", 32'(bus.res_valid), 0);
    check_eq("rst res_hit", 32'(bus.res_hit), 0);
    check_eq("rst game_over", 32'(bus.game_over), 0);
    check_eq("rst pix_cell", 32'(bus.pix_cell), 0);

    rst = 1'b0;
    wait_sweep("boot");
    check_eq("boot busy", 32'(bus.busy), 0);
    check_eq("boot ready", 32'(bus.mv_ready), 1);

    pix_check("pix 0,0", 0, 0, 2'd2);
    pix_check("pix 1,40", 1, 40, 2'd2);
    pix_check("pix 2,2", 2, 2, 2'd0);
    pix_check("pix 79,59", 79, 59, 2'd2);
    pix_check("pix 77,57", 77, 57, 2'd0);
    pix_check("pix 78,30", 78, 30, 2'd2);
    pix_check("pix col oor", 80, 0, 2'd2);
    pix_check("pix row oor", 0, 60, 2'd2);

    do_move("m1", 1'b0, 27, 30, 28, 30, 1'b0, 1'b0);
    check_eq("m1 game_over", 32'(bus.game_over), 0);
    pix_check("pix 27,30 p1", 27, 30, 2'd1);

    do_move("m2", 1'b1, 3, 30, 1, 30, 1'b1, 1'b0);
    check_eq("m2 game_over", 32'(bus.game_over), 1);
    pix_check("pix 3,30 p2", 3, 30, 2'd3);

    do_move("m3 trail", 1'b0, 28, 30, 27, 30, 1'b1, 1'b0);
    do_move("m4 col80", 1'b0, 28, 30, 80, 30, 1'b1, 1'b0);
    do_move("m5 after go", 1'b1, 40, 20, 41, 20, 1'b0, 1'b0);
    check_eq("m5 game_over sticky", 32'(bus.game_over), 1);
    pix_check("pix 40,20 p2", 40, 20, 2'd3);

    // Clear requested while the move is in flight.
    do_move("m6 clr", 1'b0, 50, 10, 51, 10, 1'b0, 1'b1);
    wait_sweep("clr after move");
    check_eq("clr game_over", 32'(bus.game_over), 0);
    pix_check("pix 27,30 cleared", 27, 30, 2'd0);
    pix_check("pix 0,0 rebuilt", 0, 0, 2'd2);

    // Clear and move together in IDLE: clear wins.
    bus.clear_req  = 1'b1;
    bus.mv_valid   = 1'b1;
    bus.mv_cur_col = 7'd20;
    bus.mv_cur_row = 6'd20;
    bus.pix_col    = 7'd0;
    bus.pix_row    = 6'd0;
    tick();
    bus.clear_req = 1'b0;
    bus.mv_valid  = 1'b0;
    check_eq("clr+mv busy", 32'(bus.busy), 1);
    repeat (10) tick();
    check_eq("pix during busy", 32'(bus.pix_cell), 0);
    // Restart mid-sweep: the full sweep runs again from the restart edge.
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    wait_sweep("restart");
    pix_check("pix 20,20 no move", 20, 20, 2'd0);

    // Reset 100 cycles into a sweep.
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    #1;
    check_eq("mid-sweep rst busy", 32'(bus.busy), 1);
    tick();
    rst = 1'b0;
    wait_sweep("rst sweep");

    // Reset during a move: no result pulse, trail swept away.
    offer_move("m7", 1'b0, 10, 10, 11, 10, ok);
    if (ok) begin
      tick();
      bus.mv_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check_eq("mid-move rst rv", 32'(bus.res_valid), 0);
      tick();
      rst = 1'b0;
      wait_sweep("rst move");
      pix_check("pix 10,10 cleared", 10, 10, 2'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arena_grid.md
ARENA_GRID -- requirements
Module: arena_grid

Interface
REQ-001 SHALL have parameter COLS, default 80, grid columns (8-pixel cells across 640).
REQ-002 SHALL have parameter ROWS, default 60, grid rows (8-pixel cells down 480).
REQ-003 SHALL have parameter BORDER, default 2, wall thickness in cells on each edge.
REQ-004 SHALL have port CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clear_req  input  1  request a full arena re-initialisation (game restart).
REQ-007 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-008 SHALL have port mv_valid/mv_ready  input/output  1/1  move handshake; a transfer occurs when both are high.
REQ-009 SHALL have port mv_player  input  1  0 = player 1, 1 = player 2.
REQ-010 SHALL have ports mv_cur_col/mv_cur_row and mv_nxt_col/mv_nxt_row  input  7/6 each  cell being left and cell being entered.
REQ-011 SHALL have ports res_valid, res_hit  output  1, 1  move-result pulse and collision flag.
REQ-012 SHALL have port game_over  output  1  sticky collision flag.
REQ-013 SHALL have ports pix_col/pix_row  input  7/6  VGA lookup cell (next_x>>3, next_y>>3); pix_cell  output  2  cell code.

Function
REQ-014 Cell codes SHALL be 0 empty, 1 player-1 trail, 2 wall, 3 player-2 trail; address = row*COLS+col, 13 bits.
REQ-015 FSM states SHALL be CLEAR, IDLE, WRITE, CHECK, RESULT.
REQ-016 CLEAR SHALL write every cell, row-major, one per cycle (COLS*ROWS = 4800 cycles); cells with row<BORDER, row>=ROWS-BORDER, col<BORDER or col>=COLS-BORDER get 2, others 0; then IDLE.
REQ-017 busy SHALL equal (state==CLEAR).
REQ-018 mv_ready SHALL be high only in IDLE with no pending clear and clear_req low.
REQ-019 On transfer: WRITE stores 1 (player 1) or 3 (player 2) at cur cell; CHECK reads nxt cell; RESULT drives res_valid high for exactly one cycle; return to IDLE.
REQ-020 Latency: transfer on edge N -> res_valid high during cycle N+3; next mv_ready at N+4 earliest.
REQ-021 res_hit SHALL be 1 if the nxt cell code is nonzero or nxt col>=COLS or nxt row>=ROWS (no memory read used for out-of-range); res_hit holds its value until next RESULT.
REQ-022 game_over SHALL set on any RESULT with res_hit=1 and clear only on entering CLEAR.
REQ-023 Moves arriving while game_over=1 SHALL still be accepted and processed.
REQ-024 clear_req in IDLE SHALL enter CLEAR next cycle; clear_req in WRITE/CHECK/RESULT SHALL be latched and serviced after RESULT (in-flight move completes first); clear_req during CLEAR SHALL restart the sweep at address 0.
REQ-025 clear_req and mv_valid together in IDLE: clear wins, no transfer.
REQ-026 pix_cell SHALL be registered, 1-cycle latency from pix_col/pix_row; out-of-range coordinates return 2; returns 0 while busy.
REQ-027 Pixel read port SHALL be independent of the move/clear port and never stall it.

Reset
REQ-028 reset high SHALL force state CLEAR at address 0, clear pending flag, mv_ready=0, res_valid=0, res_hit=0, game_over=0, pix_cell=0; busy=1.
REQ-029 After reset release the block SHALL perform the full clear sweep automatically before accepting moves.
REQ-030 Reset mid-sweep or mid-move SHALL abandon it; no partial result pulse.

Structure
REQ-031 Package arena_pkg SHALL hold COLS, ROWS, BORDER defaults, address width, cell-code constants and the FSM state encoding.
REQ-032 Storage SHALL be sub-module arena_ram: 4800x2 simple dual-port RAM, port A synchronous read/write (clear, trail write, collision read), port B synchronous read (pixel); inferable as block RAM, no reset on contents.

Verification
REQ-033 Reset release -> busy high exactly 4800 cycles; then pix (0,0)=2, (1,40)=2, (2,2)=0, (79,59)=2, (77,57)=0.
REQ-034 Move p0 cur(27,30) nxt(28,30) -> res_valid at N+3, res_hit=0; later pix (27,30)=1.
REQ-035 Move p1 cur(3,30) nxt(1,30) -> res_hit=1, game_over=1; pix (3,30)=3.
REQ-036 Move p0 into (27,30) after REQ-034 -> res_hit=1; move with nxt col 80 -> res_hit=1.
REQ-037 clear_req asserted the cycle after a transfer -> res_valid still pulses, then busy 4800 cycles, game_over=0, (27,30)=0.
REQ-038 Reset asserted 100 cycles into sweep, released -> sweep restarts from address 0, full 4800 cycles, no res_valid.
